// File: rtl/sync_handshake_tx.sv
// sync_handshake_tx
// Source side of a 4-phase req/ack crossing for one multi-bit word.
// A word is taken on the valid/ready port and held on x_data. x_req is raised
// toward the far domain, and the returning ack is synchronized before req is
// sequenced. Waits in REQ and REL are bounded by TIMEOUT (0 = wait forever).
module sync_handshake_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] x_data,
    output logic                  x_req,
    input  logic                  x_ack_async,
    output logic                  done,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    localparam int unsigned TO_W       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TO_W-1:0] CNT_LAST = CNT_LAST_I[TO_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    state_t                  state, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;
    logic [TO_W-1:0]         cnt, cnt_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    req_d;
    logic                    done_d;
    logic                    err_d;
    logic                    abort, abort_d;
    logic                    cnt_expired;

    assign ack_s       = ack_sync[SYNC_STAGES-1];
    assign s_ready     = (state == IDLE);
    assign cnt_expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Ack synchronizer: plain shift chain, ack_s is the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], x_ack_async};
        end
    end

    // Next-state and next-output logic for the IDLE/REQ/REL sequence.
    always_comb begin
        state_d = state;
        data_d  = x_data;
        req_d   = x_req;
        cnt_d   = cnt;
        done_d  = 1'b0;
        abort_d = abort;
        // Clear first so a timeout in the same cycle wins.
        err_d   = err_clr ? 1'b0 : timeout_err;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    data_d  = s_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REL;
                end else if (cnt_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    state_d = REL;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt + TO_W'(1);
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_d  = !abort;
                    abort_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    abort_d = 1'b0;
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, held word, request and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_data      <= '0;
            x_req       <= 1'b0;
            cnt         <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_d;
            x_data      <= data_d;
            x_req       <= req_d;
            cnt         <= cnt_d;
            done        <= done_d;
            timeout_err <= err_d;
            abort       <= abort_d;
        end
    end

endmodule

// File: tb/tb_sync_handshake_tx.sv
// Testbench for sync_handshake_tx: directed timing scenarios plus a randomized
// far side, with a scoreboard of accepted words checked by a monitor.
module tb_sync_handshake_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] x_data;
    logic          x_req;
    logic          x_ack_async;
    logic          done;
    logic          timeout_err;
    logic          err_clr;

    // Far-side ack source: 0 manual, 1 echo of req, 2 random-delay responder
    logic [1:0] mode    = 2'd0;
    logic       ack_man = 1'b0;
    logic       echo_ack = 1'b0;
    logic       rnd_ack = 1'b0;

    assign x_ack_async = (mode == 2'd1) ? echo_ack :
                         (mode == 2'd2) ? rnd_ack  : ack_man;

    always #5 clk = ~clk;

    sync_handshake_tx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .x_data     (x_data),
        .x_req      (x_req),
        .x_ack_async(x_ack_async),
        .done       (done),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    int unsigned   done_cnt = 0;
    int unsigned   exp_done = 0;
    logic [DW-1:0] exp_q[$];
    bit            mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Inputs change just after the falling edge; outputs read there are stable.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one word for an accept known to happen at the next edge.
    task automatic issue(input logic [DW-1:0] d);
        check("ready_before_accept", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back(d);
    endtask

    task automatic wait_done(input string name);
        int unsigned k = 0;
        while (done_cnt != exp_done && k < 300) begin
            tick();
            k++;
        end
        check(name, done_cnt, exp_done);
    endtask

    // Echo responder: ack follows req after a short wire delay.
    always begin
        @(x_req);
        #3;
        echo_ack = x_req;
    end

    // Random responder: ack edges at arbitrary phase relative to clk.
    always begin
        wait (mode == 2'd2 && x_req === 1'b1);
        #($urandom_range(1, 97));
        rnd_ack = 1'b1;
        wait (x_req === 1'b0);
        #($urandom_range(1, 97));
        rnd_ack = 1'b0;
    end

    // Monitor: at each falling edge, inputs hold what the last rising edge saw.
    logic [DW-1:0] prev_x_data  = '0;
    logic          prev_x_req   = 1'b0;
    logic          prev_s_ready = 1'b0;
    logic          prev_done    = 1'b0;
    int unsigned   ack_low_cnt  = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (x_data !== prev_x_data) begin
                if (rst === 1'b1) check("xdata_reset", x_data, 0);
                else check("xdata_change_only_on_accept", s_valid && prev_s_ready, 1);
            end
            if (prev_x_req === 1'b0 && x_req === 1'b1) begin
                if (exp_q.size() == 0) check("req_without_accept", x_req, 0);
                else check("xdata_at_req", x_data, exp_q.pop_front());
                if (mode != 2'd0) check("req_after_ack_low", ack_low_cnt >= SS + 1, 1);
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_with_ready", s_ready, 1);
                check("done_single_cycle", prev_done, 0);
            end
        end
        prev_x_data  = x_data;
        prev_x_req   = x_req;
        prev_s_ready = s_ready;
        prev_done    = done;
        if (x_ack_async === 1'b0) ack_low_cnt++;
        else ack_low_cnt = 0;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        err_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_x_req", x_req, 0);
        check("rst_x_data", x_data, 0);
        check("rst_done", done, 0);
        check("rst_err", timeout_err, 0);
        check("rst_s_ready", s_ready, 1);
        mon_on = 1'b1;
        tick();

        // Nominal transfer, ack raised 3 cycles after req
        issue(8'hA5);
        exp_done++;
        tick();
        s_valid = 1'b0;
        check("s1_req_up", x_req, 1);
        check("s1_xdata", x_data, 8'hA5);
        check("s1_ready_low", s_ready, 0);
        repeat (3) tick();
        ack_man = 1'b1;
        tick(); check("s1_req_hold0", x_req, 1);
        tick(); check("s1_req_hold1", x_req, 1);
        tick(); check("s1_req_fall", x_req, 0);
        ack_man = 1'b0;
        tick(); check("s1_done_early0", done, 0);
        tick(); check("s1_done_early1", done, 0);
        tick(); check("s1_done", done, 1); check("s1_ready_at_done", s_ready, 1);
        tick(); check("s1_done_gone", done, 0);

        // Back-to-back words with the far side echoing req
        mode = 2'd1;
        repeat (2) tick();
        s_valid = 1'b1;
        s_data  = 8'h11;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (s_ready) begin exp_q.push_back(s_data); exp_done++; ok = 1'b1; end
            tick();
        end
        check("s2_accept1", ok, 1);
        s_data = 8'h22;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            check("s2_hold_11", x_data, 8'h11);
            if (s_ready) begin exp_q.push_back(s_data); exp_done++; ok = 1'b1; end
            tick();
        end
        check("s2_accept2", ok, 1);
        s_valid = 1'b0;
        check("s2_xdata_22", x_data, 8'h22);
        wait_done("s2_done_count");
        mode = 2'd0;
        repeat (3) tick();

        // Timeout in REQ, err_clr in the setting cycle, then a clear
        issue(8'h5A);
        tick();
        s_valid = 1'b0;
        check("s3_req_up", x_req, 1);
        repeat (14) tick();
        check("s3_req_cycle15", x_req, 1);
        tick();
        check("s3_req_cycle16", x_req, 1);
        err_clr = 1'b1;
        tick();
        check("s3_req_abort", x_req, 0);
        check("s3_err_set_wins", timeout_err, 1);
        check("s3_ready_in_rel", s_ready, 0);
        tick();
        err_clr = 1'b0;
        check("s3_err_cleared", timeout_err, 0);
        check("s3_idle", s_ready, 1);
        check("s3_no_done", done, 0);
        repeat (2) tick();

        // Stuck ack: REL times out
        issue(8'hC3);
        tick();
        s_valid = 1'b0;
        ack_man = 1'b1;
        tick();
        tick(); check("s4_req_hold", x_req, 1);
        tick(); check("s4_req_fall", x_req, 0);
        repeat (15) tick();
        check("s4_err_before", timeout_err, 0);
        check("s4_ready_before", s_ready, 0);
        tick();
        check("s4_err_set", timeout_err, 1);
        check("s4_idle", s_ready, 1);
        check("s4_no_done", done, 0);

        // Ack already high at accept: REQ leaves on the first ack_s
        issue(8'h3C);
        exp_done++;
        tick();
        s_valid = 1'b0;
        check("s4b_req_up", x_req, 1);
        check("s4b_xdata", x_data, 8'h3C);
        tick();
        check("s4b_req_fall", x_req, 0);
        ack_man = 1'b0;
        tick(); check("s4b_done_early0", done, 0);
        tick(); check("s4b_done_early1", done, 0);
        tick(); check("s4b_done", done, 1);
        repeat (2) tick();

        // Reset in the middle of REQ (timeout_err still set from before)
        issue(8'h77);
        tick();
        s_valid = 1'b0;
        check("s5_req_up", x_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s5_req", x_req, 0);
        check("s5_xdata", x_data, 0);
        check("s5_ready", s_ready, 1);
        check("s5_done", done, 0);
        check("s5_err", timeout_err, 0);
        repeat (4) tick();

        // Random traffic against a random-phase, random-delay far side
        mode = 2'd2;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    s_data = DW'($urandom);
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = DW'($urandom);
            ok = 1'b0;
            for (int k = 0; k < 200 && !ok; k++) begin
                if (s_ready) begin
                    exp_q.push_back(s_data);
                    exp_done++;
                    ok = 1'b1;
                end
                tick();
                if (!ok) s_data = DW'($urandom);
            end
            if (!ok) begin
                check("s6_accept", ok, 1);
                break;
            end
            s_data = DW'($urandom);
        end
        s_valid = 1'b0;
        wait_done("s6_done_count");
        check("s6_no_err", timeout_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
